// File: rtl/tex_flash_pkg.sv
// Shared definitions for the texture-ROM SPI flash responder: the
// supported command opcodes and the responder state encoding.
package tex_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_FAST  = 8'h0B;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_t;

endpackage

// File: rtl/tex_flash_responder_if.sv
// SPI pins plus the byte-memory read port of the flash responder.
// The slave modport is the responder side, master the initiator/memory side.
interface tex_flash_responder_if #(
    parameter int ADDR_W = 12
);
    logic              spi_sclk;
    logic              spi_csb;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              busy;

    modport slave (
        input  spi_sclk, spi_csb, spi_mosi, mem_data,
        output spi_miso, spi_miso_oe, mem_addr, mem_rd, busy
    );

    modport master (
        output spi_sclk, spi_csb, spi_mosi, mem_data,
        input  spi_miso, spi_miso_oe, mem_addr, mem_rd, busy
    );
endinterface

// File: rtl/spi_edge_sync.sv
// Brings asynchronous SPI pins into the clk domain and flags SCLK/CSb edges.
// SCLK and CSb get a third stage for edge detection; MOSI is aligned to stage 2.
module spi_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic csb,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_q,
    output logic csb_fall,
    output logic mosi_q
);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic csb_p0, csb_p1, csb_p2;
    logic mosi_p0, mosi_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            csb_p0  <= 1'b0;
            csb_p1  <= 1'b0;
            csb_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            csb_p0  <= csb;
            csb_p1  <= csb_p0;
            csb_p2  <= csb_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // Starting from all-zero means a CSb held low across reset never looks
    // like a fresh select; the initiator has to raise it first.
    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign sclk_fall = ~sclk_p1 & sclk_p2;
    assign csb_q     = csb_p1;
    assign csb_fall  = ~csb_p1 & csb_p2;
    assign mosi_q    = mosi_p1;

endmodule

// File: rtl/tex_flash_responder.sv
// SPI mode-0 flash responder serving 0x03/0x0B reads from a synchronous byte
// memory and the 0x9F JEDEC ID, oversampling the SPI pins on clk.
module tex_flash_responder
    import tex_flash_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter int          FAST_DUMMY = 8
) (
    input logic                  clk,
    input logic                  reset,
    tex_flash_responder_if.slave bus
);

    // Only the low address bits (or the 8 command bits) are ever needed.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W : 8;

    function automatic logic [7:0] id_byte(input logic [1:0] n);
        case (n)
            2'd0:    return JEDEC_ID[23:16];
            2'd1:    return JEDEC_ID[15:8];
            2'd2:    return JEDEC_ID[7:0];
            default: return 8'h00;
        endcase
    endfunction

    logic sclk_rise, sclk_fall, csb_q, csb_fall, mosi_q;

    spi_edge_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (bus.spi_sclk),
        .csb       (bus.spi_csb),
        .mosi      (bus.spi_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csb_q     (csb_q),
        .csb_fall  (csb_fall),
        .mosi_q    (mosi_q)
    );

    state_t          state;
    logic [4:0]      bitcnt;
    logic [SH_W-2:0] shift_in;
    logic [SH_W-1:0] shift_nx;
    logic [7:0]      tx;
    logic [7:0]      prefetch;
    logic [7:0]      load_byte;
    logic [1:0]      idx;
    logic            fast;
    logic            rd_d;

    always_comb begin
        shift_nx  = {shift_in, mosi_q};
        load_byte = (state == DATA) ? prefetch : id_byte(idx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bitcnt          <= '0;
            shift_in        <= '0;
            tx              <= '0;
            prefetch        <= '0;
            idx             <= '0;
            fast            <= 1'b0;
            rd_d            <= 1'b0;
            bus.spi_miso    <= 1'b0;
            bus.spi_miso_oe <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_rd      <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            bus.mem_rd <= 1'b0;
            rd_d       <= bus.mem_rd;
            if (rd_d) begin
                prefetch <= bus.mem_data;
            end

            // Deselect overrides any coincident SCLK edge.
            if (csb_q) begin
                state           <= IDLE;
                bitcnt          <= '0;
                rd_d            <= 1'b0;
                bus.spi_miso_oe <= 1'b0;
                bus.busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csb_fall) begin
                            state    <= CMD;
                            bitcnt   <= '0;
                            shift_in <= '0;
                            fast     <= 1'b0;
                            bus.busy <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_in <= shift_nx[SH_W-2:0];
                            if (bitcnt == 5'd7) begin
                                bitcnt <= '0;
                                case (shift_nx[7:0])
                                    CMD_READ:  state <= ADDR;
                                    CMD_FAST: begin
                                        state <= ADDR;
                                        fast  <= 1'b1;
                                    end
                                    CMD_JEDEC: begin
                                        state <= ID;
                                        idx   <= '0;
                                    end
                                    default:   state <= IGNORE;
                                endcase
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= shift_nx[SH_W-2:0];
                            if (bitcnt == 5'd23) begin
                                bitcnt       <= '0;
                                bus.mem_addr <= shift_nx[ADDR_W-1:0];
                                bus.mem_rd   <= 1'b1;
                                state        <= fast ? DUMMY : DATA;
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sclk_rise) begin
                            if (bitcnt == 5'(FAST_DUMMY - 1)) begin
                                bitcnt <= '0;
                                state  <= DATA;
                            end else begin
                                bitcnt <= bitcnt + 5'd1;
                            end
                        end
                    end
                    DATA, ID: begin
                        if (sclk_fall) begin
                            bus.spi_miso_oe <= 1'b1;
                            bitcnt          <= (bitcnt == 5'd7) ? 5'd0 : bitcnt + 5'd1;
                            if (bitcnt == 5'd0) begin
                                bus.spi_miso <= load_byte[7];
                                tx           <= {load_byte[6:0], 1'b0};
                                // Fetch the following byte while this one shifts out.
                                if (state == DATA) begin
                                    bus.mem_addr <= bus.mem_addr + 1'b1;
                                    bus.mem_rd   <= 1'b1;
                                end else if (idx != 2'd3) begin
                                    idx <= idx + 2'd1;
                                end
                            end else begin
                                bus.spi_miso <= tx[7];
                                tx           <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                    IGNORE: begin
                        bus.spi_miso_oe <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tex_flash_responder.sv
// Bench for tex_flash_responder: drives SPI mode 0 at a 1:8 clock ratio and
// compares MISO bytes, output enable and read strobes against a byte-level model.
module tb_tex_flash_responder;
    import tex_flash_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tex_flash_responder_if #(.ADDR_W(12)) bus ();

    tex_flash_responder #(
        .ADDR_W     (12),
        .JEDEC_ID   (24'hEF4018),
        .FAST_DUMMY (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:4095];
    int rd_count = 0;
    int vectors = 0;
    int miscompares = 0;

    // Synchronous memory: data valid one clk after the strobe.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_data <= mem[bus.mem_addr];
            rd_count     <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] id_ref(input int k);
        logic [23:0] jid;
        jid = 24'hEF4018;
        if (k >= 3) return 8'h00;
        return 8'((jid >> (8 * (2 - k))) & 24'hFF);
    endfunction

    task automatic spi_bit(input logic o, input logic last, output logic i, output logic oe);
        bus.spi_mosi = o;
        repeat (4) @(negedge clk);
        i  = bus.spi_miso;
        oe = bus.spi_miso_oe;
        bus.spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.spi_sclk = 1'b0;
        if (last) bus.spi_csb = 1'b1;
    endtask

    task automatic spi_byte(input logic [7:0] o, input logic last,
                            output logic [7:0] i, output logic [7:0] oe_bits);
        logic b, e;
        for (int n = 7; n >= 0; n--) begin
            spi_bit(o[n], last && (n == 0), b, e);
            i[n]       = b;
            oe_bits[n] = e;
        end
    endtask

    task automatic select();
        bus.spi_csb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_read(input logic fast, input logic [23:0] addr, input int n, input string tag);
        logic [7:0] got, oe_bits;
        logic [11:0] a;
        int base;
        base = rd_count;
        select();
        spi_byte(fast ? CMD_FAST : CMD_READ, 1'b0, got, oe_bits);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        spi_byte(addr[23:16], 1'b0, got, oe_bits);
        spi_byte(addr[15:8], 1'b0, got, oe_bits);
        spi_byte(addr[7:0], 1'b0, got, oe_bits);
        check({tag, " oe addr"}, 32'(oe_bits), 32'h0);
        if (fast) begin
            spi_byte(8'($urandom), 1'b0, got, oe_bits);
            check({tag, " oe dummy"}, 32'(oe_bits), 32'h0);
        end
        for (int k = 0; k < n; k++) begin
            spi_byte(8'($urandom), k == n - 1, got, oe_bits);
            a = addr[11:0] + 12'(k);
            check($sformatf("%s byte%0d", tag, k), 32'(got), 32'(mem[a]));
            check($sformatf("%s oe%0d", tag, k), 32'(oe_bits), 32'hFF);
        end
        repeat (6) @(negedge clk);
        check({tag, " busy end"}, 32'(bus.busy), 32'd0);
        check({tag, " rd count"}, 32'(rd_count - base), 32'(n + 1));
    endtask

    task automatic do_id(input int n, input string tag);
        logic [7:0] got, oe_bits;
        int base;
        base = rd_count;
        select();
        spi_byte(CMD_JEDEC, 1'b0, got, oe_bits);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'($urandom), k == n - 1, got, oe_bits);
            check($sformatf("%s byte%0d", tag, k), 32'(got), 32'(id_ref(k)));
            check($sformatf("%s oe%0d", tag, k), 32'(oe_bits), 32'hFF);
        end
        repeat (6) @(negedge clk);
        check({tag, " rd count"}, 32'(rd_count - base), 32'd0);
    endtask

    initial begin
        logic [7:0] got, oe_bits;
        logic b, e;

        bus.spi_csb  = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'hA5;

        // Reset with random SCLK/MOSI activity and CSb high.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.spi_sclk = 1'($urandom);
            bus.spi_mosi = 1'($urandom);
            check("rst oe", 32'(bus.spi_miso_oe), 32'd0);
            check("rst busy", 32'(bus.busy), 32'd0);
            check("rst mem_rd", 32'(bus.mem_rd), 32'd0);
        end
        check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst miso", 32'(bus.spi_miso), 32'd0);
        reset = 1'b0;
        bus.spi_sclk = 1'b0;
        repeat (8) @(negedge clk);
        check("idle oe", 32'(bus.spi_miso_oe), 32'd0);
        check("idle busy", 32'(bus.busy), 32'd0);
        check("idle rd count", 32'(rd_count), 32'd0);

        do_read(1'b0, 24'h000010, 4, "read");
        do_read(1'b1, 24'h000FFE, 4, "fast wrap");
        do_id(5, "jedec");

        // Abort after 13 address bits, then a clean read.
        select();
        spi_byte(CMD_READ, 1'b0, got, oe_bits);
        spi_byte(8'h00, 1'b0, got, oe_bits);
        for (int n = 0; n < 5; n++) spi_bit(1'b1, n == 4, b, e);
        repeat (6) @(negedge clk);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort oe", 32'(bus.spi_miso_oe), 32'd0);
        do_read(1'b0, 24'h000000, 1, "after abort");

        // Unknown command keeps MISO released.
        select();
        spi_byte(8'h5A, 1'b0, got, oe_bits);
        spi_byte(8'($urandom), 1'b0, got, oe_bits);
        check("badcmd oe0", 32'(oe_bits), 32'h0);
        spi_byte(8'($urandom), 1'b1, got, oe_bits);
        check("badcmd oe1", 32'(oe_bits), 32'h0);
        repeat (6) @(negedge clk);
        do_id(3, "after badcmd");

        // Async reset in the middle of the second data byte.
        select();
        spi_byte(CMD_READ, 1'b0, got, oe_bits);
        spi_byte(8'h00, 1'b0, got, oe_bits);
        spi_byte(8'h00, 1'b0, got, oe_bits);
        spi_byte(8'h40, 1'b0, got, oe_bits);
        spi_byte(8'h00, 1'b0, got, oe_bits);
        check("mid byte0", 32'(got), 32'(mem[12'h040]));
        for (int n = 0; n < 4; n++) spi_bit(1'b0, 1'b0, b, e);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async oe", 32'(bus.spi_miso_oe), 32'd0);
        check("async miso", 32'(bus.spi_miso), 32'd0);
        check("async busy", 32'(bus.busy), 32'd0);
        check("async mem_rd", 32'(bus.mem_rd), 32'd0);
        check("async mem_addr", 32'(bus.mem_addr), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        bus.spi_csb = 1'b1;
        repeat (6) @(negedge clk);
        do_read(1'b0, 24'h000020, 1, "after reset");
        check("after reset value", 32'(mem[12'h020]), 32'h85);

        // Random transactions over random memory contents.
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 8; t++) begin
            do_read(1'($urandom), 24'($urandom), int'($urandom_range(1, 5)),
                    $sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
